// File: rtl/fft_pkg.sv
// fft_pkg: shared state type and elaboration-time helpers (bit reversal, twiddle
// constants) for the iterative radix-2 FFT engine.
package fft_pkg;

    localparam int FRAC_BITS_DEF = 15;

    typedef enum logic [1:0] {S_LOAD, S_COMP, S_OUT} state_t;

    localparam longint PI_Q30 = 64'sd3373259426;

    function automatic int bitrev(input int value, input int bits);
        int r;
        r = 0;
        for (int i = 0; i < bits; i++)
            r[bits-1-i] = value[i];
        return r;
    endfunction

    // Taylor series in Q30 for an angle in [0, pi/2]; residual error is far below one Q15 LSB.
    function automatic longint sincos_q30(input longint x, input bit want_sin);
        longint x2, term, acc, d;
        x2   = (x * x) >>> 30;
        term = want_sin ? x : (64'sd1 <<< 30);
        acc  = term;
        for (int k = 1; k < 12; k++) begin
            d    = want_sin ? longint'((2*k) * (2*k + 1)) : longint'((2*k - 1) * (2*k));
            term = -(((term * x2) >>> 30) / d);
            acc  = acc + term;
        end
        return acc;
    endfunction

    // Rounded magnitude of cos/sin(2*pi*t/n) in Q.frac; angles past pi/2 fold onto pi-angle.
    function automatic longint tw_mag(input int t, input int n, input int frac, input bit want_sin);
        int     u;
        longint v;
        u = (4*t > n) ? n/2 - t : t;
        v = sincos_q30((PI_Q30 * 2 * longint'(u)) / longint'(n), want_sin);
        if (v < 64'sd0)
            v = 64'sd0;
        return (v + (64'sd1 <<< (29 - frac))) >>> (30 - frac);
    endfunction

    function automatic int tw_re(input int t, input int n, input int frac);
        longint v;
        v = tw_mag(t, n, frac, 1'b0);
        if (4*t > n)
            v = -v;
        else if (v > (64'sd1 <<< frac) - 64'sd1)
            v = (64'sd1 <<< frac) - 64'sd1;
        return int'(v);
    endfunction

    function automatic int tw_im(input int t, input int n, input int frac);
        return -int'(tw_mag(t, n, frac, 1'b1));
    endfunction

endpackage

// File: rtl/fft_bf_core.sv
// fft_bf_core: combinational radix-2 DIT butterfly, x = a + b*w and y = a - b*w.
// Defining FFT_STAGE_SCALE_EN halves both outputs (round half up) after the add/sub.
module fft_bf_core #(
    parameter int DATA_WIDTH = 21,
    parameter int FRAC_BITS  = 15
) (
    input  logic signed [DATA_WIDTH-1:0] a_re,
    input  logic signed [DATA_WIDTH-1:0] a_im,
    input  logic signed [DATA_WIDTH-1:0] b_re,
    input  logic signed [DATA_WIDTH-1:0] b_im,
    input  logic signed [FRAC_BITS:0]    w_re,
    input  logic signed [FRAC_BITS:0]    w_im,
    output logic signed [DATA_WIDTH-1:0] x_re,
    output logic signed [DATA_WIDTH-1:0] x_im,
    output logic signed [DATA_WIDTH-1:0] y_re,
    output logic signed [DATA_WIDTH-1:0] y_im
);

    localparam int PW = DATA_WIDTH + FRAC_BITS + 2;
    localparam int SW = DATA_WIDTH + 1;

    logic signed [PW-1:0] prod_re;
    logic signed [PW-1:0] prod_im;
    logic signed [SW-1:0] p_re;
    logic signed [SW-1:0] p_im;

    function automatic logic signed [DATA_WIDTH-1:0] stage_out(input logic signed [SW-1:0] v);
`ifdef FFT_STAGE_SCALE_EN
        logic signed [SW:0] r;
        r = (SW+1)'(v) + (SW+1)'(1);
        return r[DATA_WIDTH:1];
`else
        return v[DATA_WIDTH-1:0];
`endif
    endfunction

    always_comb begin
        prod_re = PW'(b_re) * PW'(w_re) - PW'(b_im) * PW'(w_im);
        prod_im = PW'(b_re) * PW'(w_im) + PW'(b_im) * PW'(w_re);
        p_re    = SW'(prod_re >>> FRAC_BITS);
        p_im    = SW'(prod_im >>> FRAC_BITS);
        x_re    = stage_out(SW'(a_re) + p_re);
        x_im    = stage_out(SW'(a_im) + p_im);
        y_re    = stage_out(SW'(a_re) - p_re);
        y_im    = stage_out(SW'(a_im) - p_im);
    end

endmodule

// File: rtl/fft_iter_r2.sv
// fft_iter_r2: iterative in-place radix-2 DIT FFT of N real samples, one butterfly per cycle.
// Optional FFT_STAGE_SCALE_EN (applied in fft_bf_core) divides every stage by 2.
module fft_iter_r2
    import fft_pkg::*;
#(
    parameter int N          = 8,
    parameter int IN_WIDTH   = 16,
    parameter int FRAC_BITS  = FRAC_BITS_DEF,
    parameter int DATA_WIDTH = IN_WIDTH + $clog2(N) + 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic signed [IN_WIDTH-1:0]   x_re_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    output logic signed [DATA_WIDTH-1:0] y_re_o,
    output logic signed [DATA_WIDTH-1:0] y_im_o,
    output logic [$clog2(N)-1:0]         y_idx_o,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic                         last_o,
    output logic                         busy_o
);

    localparam int LOG2N = $clog2(N);
    localparam int AW    = LOG2N;
    localparam int TW    = LOG2N - 1;

    state_t state, state_nxt;

    logic [AW-1:0] k, s, b, m;
    logic [AW-1:0] h, j, top, bot, wr_idx;
    logic [TW-1:0] t;
    logic          load_fire, comp_fire, comp_last, out_fire;

    logic signed [FRAC_BITS:0]    tw_re_tab [N/2];
    logic signed [FRAC_BITS:0]    tw_im_tab [N/2];
    logic signed [DATA_WIDTH-1:0] mem_re [N];
    logic signed [DATA_WIDTH-1:0] mem_im [N];
    logic signed [DATA_WIDTH-1:0] x_re, x_im, y_re, y_im;

    for (genvar i = 0; i < N/2; i++) begin : g_tw
        assign tw_re_tab[i] = (FRAC_BITS+1)'(tw_re(i, N, FRAC_BITS));
        assign tw_im_tab[i] = (FRAC_BITS+1)'(tw_im(i, N, FRAC_BITS));
    end

    // Butterfly addressing: top = g*2h + j, bot = top + h, twiddle stride grows as stages shrink.
    always_comb begin
        h      = AW'(1) << s;
        j      = b & (h - AW'(1));
        top    = ((b >> s) << (s + AW'(1))) | j;
        bot    = top + h;
        t      = TW'(j << (AW'(LOG2N - 1) - s));
        wr_idx = AW'(bitrev(int'(k), LOG2N));
    end

    always_comb begin
        state_nxt = state;
        load_fire = 1'b0;
        comp_fire = 1'b0;
        comp_last = 1'b0;
        out_fire  = 1'b0;
        ready_o   = 1'b0;
        valid_o   = 1'b0;
        busy_o    = 1'b0;
        last_o    = 1'b0;
        case (state)
            S_LOAD: begin
                ready_o   = 1'b1;
                load_fire = valid_i;
                if (valid_i && k == AW'(N - 1))
                    state_nxt = S_COMP;
            end
            S_COMP: begin
                busy_o    = 1'b1;
                comp_fire = 1'b1;
                comp_last = (s == AW'(LOG2N - 1)) && (b == AW'(N/2 - 1));
                if (comp_last)
                    state_nxt = S_OUT;
            end
            S_OUT: begin
                valid_o  = 1'b1;
                last_o   = (m == AW'(N - 1));
                out_fire = ready_i;
                if (ready_i && m == AW'(N - 1))
                    state_nxt = S_LOAD;
            end
            default: state_nxt = S_LOAD;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state <= S_LOAD;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            k <= '0;
            s <= '0;
            b <= '0;
            m <= '0;
        end else begin
            if (load_fire)
                k <= k + AW'(1);
            if (comp_fire) begin
                if (b == AW'(N/2 - 1)) begin
                    b <= '0;
                    s <= comp_last ? '0 : s + AW'(1);
                end else begin
                    b <= b + AW'(1);
                end
            end
            if (out_fire)
                m <= m + AW'(1);
        end
    end

    // Sample array holds data only; it is rewritten entirely by every frame.
    always_ff @(posedge clk_i) begin
        if (load_fire) begin
            mem_re[wr_idx] <= DATA_WIDTH'(x_re_i);
            mem_im[wr_idx] <= '0;
        end
        if (comp_fire) begin
            mem_re[top] <= x_re;
            mem_im[top] <= x_im;
            mem_re[bot] <= y_re;
            mem_im[bot] <= y_im;
        end
    end

    fft_bf_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS)
    ) u_bf (
        .a_re (mem_re[top]),
        .a_im (mem_im[top]),
        .b_re (mem_re[bot]),
        .b_im (mem_im[bot]),
        .w_re (tw_re_tab[t]),
        .w_im (tw_im_tab[t]),
        .x_re (x_re),
        .x_im (x_im),
        .y_re (y_re),
        .y_im (y_im)
    );

    assign y_re_o  = valid_o ? mem_re[m] : '0;
    assign y_im_o  = valid_o ? mem_im[m] : '0;
    assign y_idx_o = m;

endmodule

// File: tb/tb_fft_iter_r2.sv
// tb_fft_iter_r2: directed bench for fft_iter_r2 at N=8 and N=16, with hand-computed bins.
// Expected values follow FFT_STAGE_SCALE_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_fft_iter_r2;

    localparam int DW8  = 21;
    localparam int DW16 = 22;
`ifdef FFT_STAGE_SCALE_EN
    localparam int SH8  = 3;
    localparam int SH16 = 4;
`else
    localparam int SH8  = 0;
    localparam int SH16 = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic signed [15:0]      x8, x16;
    logic                    v8, v16, rin8, rin16;
    logic                    rdy8, rdy16, vo8, vo16, last8, last16, busy8, busy16;
    logic signed [DW8-1:0]   yre8, yim8;
    logic signed [DW16-1:0]  yre16, yim16;
    logic [2:0]              idx8;
    logic [3:0]              idx16;

    int n_checks = 0;
    int n_fail   = 0;

    logic signed [15:0] smp [16];
    longint got_re [16];
    longint got_im [16];
    longint exp_re [16];

    always #5 clk = ~clk;

    fft_iter_r2 dut8 (
        .clk_i (clk), .rst_i (rst), .x_re_i (x8), .valid_i (v8), .ready_o (rdy8),
        .y_re_o (yre8), .y_im_o (yim8), .y_idx_o (idx8), .valid_o (vo8),
        .ready_i (rin8), .last_o (last8), .busy_o (busy8)
    );

    fft_iter_r2 #(.N(16)) dut16 (
        .clk_i (clk), .rst_i (rst), .x_re_i (x16), .valid_i (v16), .ready_o (rdy16),
        .y_re_o (yre16), .y_im_o (yim16), .y_idx_o (idx16), .valid_o (vo16),
        .ready_i (rin16), .last_o (last16), .busy_o (busy16)
    );

    task automatic check_val(input string tag, input longint obs, input longint exp, input longint tol);
        longint d;
        n_checks++;
        d = obs - exp;
        if (d < 0) d = -d;
        if (d > tol) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    task automatic send(input bit wide, input int n);
        int i = 0;
        int guard = 0;
        bit r;
        while (i < n && guard < 200) begin
            @(negedge clk);
            r = wide ? rdy16 : rdy8;
            if (wide) begin x16 = smp[i]; v16 = 1'b1; end
            else      begin x8  = smp[i]; v8  = 1'b1; end
            if (r) i++;
            guard++;
        end
        check_val("load_count", longint'(i), longint'(n), 0);
        @(posedge clk);
        #1;
        v8  = 1'b0;
        v16 = 1'b0;
    endtask

    task automatic receive(input bit wide, input int n, input int stall_idx, output int busy_n);
        int m = 0, guard = 0, stall = 0, idx = 0, hold_idx = 0;
        bit vo, lst, rdy_seen, rdy_now;
        longint re, im, hold_re, hold_im;
        busy_n = 0;
        rdy_seen = 1'b0;
        hold_re = 0;
        hold_im = 0;
        while (m < n && guard < 500) begin
            @(negedge clk);
            guard++;
            if (wide) begin
                vo = vo16; lst = last16; re = longint'(yre16); im = longint'(yim16);
                idx = int'(idx16); rdy_now = rdy16;
                if (busy16) busy_n++;
            end else begin
                vo = vo8; lst = last8; re = longint'(yre8); im = longint'(yim8);
                idx = int'(idx8); rdy_now = rdy8;
                if (busy8) busy_n++;
            end
            if (rdy_now) rdy_seen = 1'b1;
            if (vo) begin
                if (idx == stall_idx) begin
                    if (stall == 0) begin
                        hold_re = re; hold_im = im; hold_idx = idx;
                    end else begin
                        check_val("stall_re",  re, hold_re, 0);
                        check_val("stall_im",  im, hold_im, 0);
                        check_val("stall_idx", longint'(idx), longint'(hold_idx), 0);
                    end
                end
                if (idx == stall_idx && stall < 3) begin
                    stall++;
                    if (wide) rin16 = 1'b0; else rin8 = 1'b0;
                end else begin
                    if (wide) rin16 = 1'b1; else rin8 = 1'b1;
                    check_val($sformatf("order_idx%0d", m), longint'(idx), longint'(m), 0);
                    check_val($sformatf("last_idx%0d", m), longint'(lst), longint'(m == n - 1), 0);
                    got_re[m] = re;
                    got_im[m] = im;
                    m++;
                end
            end
        end
        check_val("unload_count", longint'(m), longint'(n), 0);
        check_val("ready_low_until_last", longint'(rdy_seen), 0, 0);
        @(negedge clk);
        check_val("post_valid", longint'(wide ? vo16 : vo8), 0, 0);
        check_val("post_ready", longint'(wide ? rdy16 : rdy8), 1, 0);
    endtask

    task automatic check_bins(input string tag, input int n, input longint tol);
        for (int q = 0; q < n; q++) begin
            check_val($sformatf("%s_re%0d", tag, q), got_re[q], exp_re[q], tol);
            check_val($sformatf("%s_im%0d", tag, q), got_im[q], 0, tol);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bn;
        logic signed [15:0] cos16 [16];
        cos16 = '{16'sd16384, 16'sd15137, 16'sd11585, 16'sd6270, 16'sd0, -16'sd6270, -16'sd11585, -16'sd15137,
                  -16'sd16384, -16'sd15137, -16'sd11585, -16'sd6270, 16'sd0, 16'sd6270, 16'sd11585, 16'sd15137};
        x8 = '0; x16 = '0; v8 = 1'b0; v16 = 1'b0; rin8 = 1'b1; rin16 = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_val("rst_ready", longint'(rdy8), 1, 0);
        check_val("rst_valid", longint'(vo8), 0, 0);
        check_val("rst_last",  longint'(last8), 0, 0);
        check_val("rst_busy",  longint'(busy8), 0, 0);
        check_val("rst_yre",   longint'(yre8), 0, 0);
        check_val("rst_yim",   longint'(yim8), 0, 0);
        check_val("rst_idx",   longint'(idx8), 0, 0);
        rst = 1'b0;

        // impulse: every bin equals the impulse height
        for (int i = 0; i < 8; i++) smp[i] = (i == 0) ? 16'sh4000 : 16'sh0000;
        send(1'b0, 8);
        receive(1'b0, 8, -1, bn);
        check_val("imp_busy_cycles", longint'(bn), 12, 0);
        for (int i = 0; i < 8; i++) exp_re[i] = 64'sd16384 >>> SH8;
        check_bins("imp", 8, 0);

        // DC with a three-cycle stall at bin 2
        for (int i = 0; i < 8; i++) smp[i] = 16'sh1000;
        send(1'b0, 8);
        receive(1'b0, 8, 2, bn);
        check_val("dc_busy_cycles", longint'(bn), 12, 0);
        for (int i = 0; i < 8; i++) exp_re[i] = (i == 0) ? (64'sd32768 >>> SH8) : 64'sd0;
        check_bins("dc", 8, 8);

        // alternating sign: all energy in the Nyquist bin
        for (int i = 0; i < 8; i++) smp[i] = (i % 2 == 0) ? 16'sh2000 : -16'sh2000;
        send(1'b0, 8);
        receive(1'b0, 8, -1, bn);
        for (int i = 0; i < 8; i++) exp_re[i] = (i == 4) ? (64'sd65536 >>> SH8) : 64'sd0;
        check_bins("alt", 8, 8);

        // reset in the middle of compute, then a clean impulse frame
        for (int i = 0; i < 8; i++) smp[i] = 16'sh1000;
        send(1'b0, 8);
        repeat (3) @(negedge clk);
        check_val("midcomp_busy", longint'(busy8), 1, 0);
        rst = 1'b1;
        @(negedge clk);
        check_val("midrst_ready", longint'(rdy8), 1, 0);
        check_val("midrst_valid", longint'(vo8), 0, 0);
        check_val("midrst_busy",  longint'(busy8), 0, 0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) smp[i] = (i == 0) ? 16'sh4000 : 16'sh0000;
        send(1'b0, 8);
        receive(1'b0, 8, -1, bn);
        for (int i = 0; i < 8; i++) exp_re[i] = 64'sd16384 >>> SH8;
        check_bins("rec", 8, 0);

        // N=16 cosine at bin 1
        for (int i = 0; i < 16; i++) smp[i] = cos16[i];
        send(1'b1, 16);
        receive(1'b1, 16, -1, bn);
        check_val("cos_busy_cycles", longint'(bn), 32, 0);
        for (int i = 0; i < 16; i++) exp_re[i] = (i == 1 || i == 15) ? (64'sd131072 >>> SH16) : 64'sd0;
        check_bins("cos", 16, 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_iter_r2.md
Name: fft_iter_r2

Overview:
- Iterative radix-2 decimation-in-time FFT engine, parametrised in transform length N; generalises the fixed 8-point combinational FFT.
- Accepts N real Q1.15 samples serially over a valid/ready stream and stores them bit-reversed in an internal register array.
- Computes log2(N) stages with one shared butterfly, one butterfly per cycle, then streams N complex bins out in natural order.
- Sits between the sample capture front end and the magnitude/CORDIC back end.

Parameters:
- N, 8: transform length; power of two, 4..256.
- IN_WIDTH, 16: input sample width, Q1.15.
- FRAC_BITS, 15: fractional bits of samples and twiddles.
- DATA_WIDTH, IN_WIDTH+$clog2(N)+2: internal and output width. The default is 21 (N=8).

Ports:
- clk_i, input, 1: clock.
- rst_i, input, 1: reset, asynchronous, active-high.
- x_re_i, input, IN_WIDTH: real time-domain sample, signed Q1.15.
- valid_i, input, 1: x_re_i valid.
- ready_o, output, 1: engine accepts a sample.
- y_re_o, output, DATA_WIDTH: bin real part, signed.
- y_im_o, output, DATA_WIDTH: bin imaginary part, signed.
- y_idx_o, output, $clog2(N): bin index of current output.
- valid_o, output, 1: output bin valid.
- ready_i, input, 1: downstream accepts a bin.
- last_o, output, 1: high with the bin at index N-1.
- busy_o, output, 1: high in S_COMP.

Behaviour:
- Clock, reset and width:
  - One clock domain. Reset is asynchronous and active-high.
  - Reset values: state=S_LOAD, all counters 0, ready_o=1, valid_o=0, last_o=0, busy_o=0, y_*_o=0, y_idx_o=0.
  - Sample array is not cleared on reset.
- S_LOAD:
  - ready_o=1.
  - On valid_i&&ready_o, sign-extend the sample to DATA_WIDTH and write it to array[bitrev(k)]; imag=0; k increments.
  - When the N-th sample is accepted, go to S_COMP next cycle with ready_o=0.
  - valid_i while ready_o=0 is ignored. No input is dropped inside S_LOAD.
- S_COMP:
  - Stage counter s runs 0..log2(N)-1; butterfly counter b runs 0..N/2-1; one butterfly per cycle.
  - Half span h=1<<s. Indices: j=b mod h, g=b/h.
  - Operands: top=g*2h+j, bot=top+h. Twiddle index t=j<<(log2(N)-1-s).
  - Each cycle reads two entries, applies the butterfly, and writes back in place in the same cycle.
  - Butterfly: p=bot*W^t as full-precision complex products, arithmetic-shifted right by FRAC_BITS (truncation). Outputs are top+p and top-p, each truncated to DATA_WIDTH. No saturation.
  - Compute takes exactly (N/2)*log2(N) cycles (12 for N=8). Then go to S_OUT.
- Twiddles:
  - W^t = cos(2πt/N) - j·sin(2πt/N) in Q.FRAC_BITS, rounded to nearest.
  - +1.0 is clamped to 2^FRAC_BITS-1.
  - Table of N/2 entries built at elaboration by a constant function.
- S_OUT:
  - valid_o=1 and presents array[m] with y_idx_o=m for m=0..N-1.
  - m advances only on valid_o&&ready_i. Outputs stay stable while ready_i=0.
  - last_o=1 when m=N-1. The handshake on the last bin returns to S_LOAD next cycle with valid_o=0 and ready_o=1.
- Load and unload never overlap: frame throughput is one frame per 2N+(N/2)log2(N) cycles minimum.
- Reset mid-frame: immediate return to S_LOAD. The partial frame is discarded and the next N samples form a new frame.

Optional Feature:
- FFT_STAGE_SCALE_EN:
  - When defined, each butterfly output is divided by 2 with an arithmetic shift right and round-half-up after the add/sub.
  - The final result is X[k]/N, so no growth beyond input range.
- When undefined, there is no scaling: full growth, absorbed by the guard bits in DATA_WIDTH.

Decomposition:
- Package fft_pkg holds:
  - the state enum S_LOAD/S_COMP/S_OUT;
  - the function bitrev(value,bits);
  - the twiddle constant function tw_re(t,N)/tw_im(t,N);
  - the default FRAC_BITS.
- One sub-module, fft_bf_core: combinational complex butterfly parametrised in DATA_WIDTH/FRAC_BITS. The scaling macro is applied inside it.
- The top level holds the FSM, counters and array.

Test Plan:
- N=8, impulse x[0]=0x4000, rest 0 -> all 8 bins re=0x04000, im=0. valid_o spans exactly 8 handshakes and last_o is high on idx 7.
- N=8 DC, all samples 0x1000 -> bin0 re=0x08000, all other bins re=im=0. Check busy_o is high for exactly 12 cycles.
- N=8 alternating +0x2000/-0x2000 -> bin4 re=0x10000, others 0. With FFT_STAGE_SCALE_EN: bin4 re=0x02000.
- N=16 cosine x[n]=round(0x4000·cos(2πn/16)) -> bins 1 and 15 re=0x20000 ±4 LSB, all other bins |val|≤4 LSB.
- Backpressure: ready_i low for 3 cycles at idx 2 during unload -> y_*_o/y_idx_o held, no bin skipped or repeated. ready_o stays 0 until the last handshake.
- Assert rst_i during S_COMP -> the next cycle shows ready_o=1, valid_o=0. A following impulse frame yields correct bins.
